// File: rtl/tpg_pkg.sv
// Shared types and constants for the test-pattern generator.
package tpg_pkg;

  typedef enum logic [2:0] {
    SOLID = 3'd0,
    BARS  = 3'd1,
    RAMP  = 3'd2,
    CHECK = 3'd3
  } tpg_mode_e;

  localparam int unsigned NUM_BARS = 8;

  // Colour-bar on/off table {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [2:0] BAR_RGB [NUM_BARS] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

endpackage

// File: rtl/tpg_timing.sv
// Raster timing: h/v counters, sync and active flags, active-area coordinates.
// The frame-end flag port exists only when TPG_SCROLL_EN is defined.
module tpg_timing #(
  parameter int unsigned H_ACT  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_ACT  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  localparam int unsigned H_TOT = H_SYNC + H_BP + H_ACT + H_FP,
  localparam int unsigned V_TOT = V_SYNC + V_BP + V_ACT + V_FP,
  localparam int unsigned HW    = $clog2(H_TOT),
  localparam int unsigned VW    = $clog2(V_TOT)
) (
  input  logic          px_clk,
  input  logic          sys_rst,
  input  logic          en,
  output logic          hs_c,
  output logic          vs_c,
  output logic          act_c,
  output logic          sof_c,
  output logic          fstart_c,
  output logic [HW-1:0] x_c,
  output logic [VW-1:0] y_c
`ifdef TPG_SCROLL_EN
  ,
  output logic          fend_c
`endif
);

  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned H_END   = H_START + H_ACT;
  localparam int unsigned V_START = V_SYNC + V_BP;
  localparam int unsigned V_END   = V_START + V_ACT;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          h_last;
  logic          v_last;

  assign h_last = (32'(hcnt) == H_TOT - 1);
  assign v_last = (32'(vcnt) == V_TOT - 1);

  // Counters sit at the frame origin whenever the generator is disabled.
  always_ff @(posedge px_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!en) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  assign hs_c     = en && (32'(hcnt) < H_SYNC);
  assign vs_c     = en && (32'(vcnt) < V_SYNC);
  assign act_c    = en && (32'(hcnt) >= H_START) && (32'(hcnt) < H_END)
                       && (32'(vcnt) >= V_START) && (32'(vcnt) < V_END);
  assign sof_c    = act_c && (32'(hcnt) == H_START) && (32'(vcnt) == V_START);
  assign fstart_c = (hcnt == '0) && (vcnt == '0);
  assign x_c      = hcnt - HW'(H_START);
  assign y_c      = vcnt - VW'(V_START);

`ifdef TPG_SCROLL_EN
  assign fend_c   = en && h_last && v_last;
`endif

endmodule

// File: rtl/tpg_param.sv
// Parametrised video test-pattern generator: raster timing plus registered RGB pattern stage.
// Define TPG_SCROLL_EN to scroll all patterns left by one pixel per frame.
module tpg_param
  import tpg_pkg::*;
#(
  parameter int unsigned H_ACT    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACT    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned DW       = 8,
  parameter int unsigned CHK_LOG2 = 5
) (
  input  logic            px_clk,
  input  logic            sys_rst,
  input  logic            en,
  input  logic [2:0]      mode_i,
  input  logic [3*DW-1:0] solid_i,
  output logic            vsync_o,
  output logic            hsync_o,
  output logic            dval_o,
  output logic            sof_o,
  output logic [DW-1:0]   rdata_o,
  output logic [DW-1:0]   gdata_o,
  output logic [DW-1:0]   bdata_o
);

  localparam int unsigned H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);
  localparam int unsigned BAR_W = (H_ACT / NUM_BARS > 0) ? H_ACT / NUM_BARS : 1;
  localparam int unsigned PW    = $clog2(BAR_W) + 1;
  localparam logic        SP    = 1'(SYNC_POL);

  logic            hs_c, vs_c, act_c, sof_c, fstart_c;
  logic [HW-1:0]   x_c, xs_c, offset;
  logic [HW:0]     xsum_c;
  logic [VW-1:0]   y_c;
  logic [3:0]      bar_q, off_bar;
  logic [PW-1:0]   pib_q, off_pib;
  logic [2:0]      bar_on_c;
  logic            chk_c;
  logic [3*DW-1:0] pix_c, solid_q;
  tpg_mode_e       mode_q;
`ifdef TPG_SCROLL_EN
  logic            fend_c;
`endif

  // Advance a {bar index, pixel-in-bar} position by one pixel; index 8 is the black tail.
  function automatic logic [PW+3:0] bar_step(input logic [3:0] b, input logic [PW-1:0] p);
    if (32'(p) == BAR_W - 1)
      return {(b == 4'(NUM_BARS)) ? b : b + 4'd1, PW'(0)};
    return {b, p + PW'(1)};
  endfunction

  tpg_timing #(
    .H_ACT  (H_ACT),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_ACT  (V_ACT),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_timing (
    .px_clk   (px_clk),
    .sys_rst  (sys_rst),
    .en       (en),
    .hs_c     (hs_c),
    .vs_c     (vs_c),
    .act_c    (act_c),
    .sof_c    (sof_c),
    .fstart_c (fstart_c),
    .x_c      (x_c),
    .y_c      (y_c)
`ifdef TPG_SCROLL_EN
    ,
    .fend_c   (fend_c)
`endif
  );

  // Pattern selection is frozen for the whole frame.
  always_ff @(posedge px_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q  <= SOLID;
      solid_q <= '0;
    end else if (fstart_c) begin
      mode_q  <= tpg_mode_e'(mode_i);
      solid_q <= solid_i;
    end
  end

`ifdef TPG_SCROLL_EN
  // Per-frame x offset, with its bar position tracked alongside to avoid a divider.
  always_ff @(posedge px_clk or posedge sys_rst) begin
    if (sys_rst) begin
      offset  <= '0;
      off_bar <= '0;
      off_pib <= '0;
    end else if (!en) begin
      offset  <= '0;
      off_bar <= '0;
      off_pib <= '0;
    end else if (fend_c) begin
      if (32'(offset) == H_ACT - 1) begin
        offset  <= '0;
        off_bar <= '0;
        off_pib <= '0;
      end else begin
        offset             <= offset + HW'(1);
        {off_bar, off_pib} <= bar_step(off_bar, off_pib);
      end
    end
  end
`else
  assign offset  = '0;
  assign off_bar = '0;
  assign off_pib = '0;
`endif

  assign xsum_c = {1'b0, x_c} + {1'b0, offset};
  assign xs_c   = (32'(xsum_c) >= H_ACT) ? HW'(32'(xsum_c) - H_ACT) : HW'(xsum_c);

  // Bar position of the current pixel; reloaded from the frame offset outside the active area.
  always_ff @(posedge px_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bar_q <= '0;
      pib_q <= '0;
    end else if (!act_c) begin
      bar_q <= off_bar;
      pib_q <= off_pib;
    end else if (32'(xs_c) == H_ACT - 1) begin
      bar_q <= '0;
      pib_q <= '0;
    end else begin
      {bar_q, pib_q} <= bar_step(bar_q, pib_q);
    end
  end

  assign bar_on_c = (bar_q < 4'(NUM_BARS)) ? BAR_RGB[bar_q[2:0]] : 3'b000;
  assign chk_c    = 1'(xs_c >> CHK_LOG2) ^ 1'(y_c >> CHK_LOG2);

  always_comb begin
    pix_c = '0;
    case (mode_q)
      SOLID:   pix_c = solid_q;
      BARS:    pix_c = {{DW{bar_on_c[2]}}, {DW{bar_on_c[1]}}, {DW{bar_on_c[0]}}};
      RAMP:    pix_c = {3{DW'(xs_c)}};
      CHECK:   pix_c = {(3*DW){chk_c}};
      default: pix_c = '0;
    endcase
  end

  // Output register stage: one clock behind the counters, all outputs aligned.
  always_ff @(posedge px_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hsync_o <= ~SP;
      vsync_o <= ~SP;
      dval_o  <= 1'b0;
      sof_o   <= 1'b0;
      rdata_o <= '0;
      gdata_o <= '0;
      bdata_o <= '0;
    end else begin
      hsync_o <= hs_c ? SP : ~SP;
      vsync_o <= vs_c ? SP : ~SP;
      dval_o  <= act_c;
      sof_o   <= sof_c;
      rdata_o <= act_c ? pix_c[3*DW-1 -: DW] : '0;
      gdata_o <= act_c ? pix_c[2*DW-1 -: DW] : '0;
      bdata_o <= act_c ? pix_c[DW-1:0]       : '0;
    end
  end

endmodule

// File: tb/tb_tpg_param.sv
// Self-checking bench for tpg_param on a small raster, against a time-indexed reference model.
module tb_tpg_param;

  localparam int H_ACT = 16, H_FP = 2, H_SYNC = 2, H_BP = 2;
  localparam int V_ACT = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int CHK = 2;
  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int FT = H_TOT * V_TOT;
  localparam int HS = H_SYNC + H_BP;
  localparam int VS = V_SYNC + V_BP;
  localparam logic [23:0] BAR_COL [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };
  localparam logic [27:0] IDLE = {1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};

  logic        px_clk, sys_rst, en;
  logic [2:0]  mode_i;
  logic [23:0] solid_i;
  logic        vsync_o, hsync_o, dval_o, sof_o;
  logic [7:0]  rdata_o, gdata_o, bdata_o;
  logic [27:0] obs;

  int checks = 0;
  int errors = 0;

  tpg_param #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(0), .DW(8), .CHK_LOG2(CHK)
  ) dut (
    .px_clk  (px_clk),
    .sys_rst (sys_rst),
    .en      (en),
    .mode_i  (mode_i),
    .solid_i (solid_i),
    .vsync_o (vsync_o),
    .hsync_o (hsync_o),
    .dval_o  (dval_o),
    .sof_o   (sof_o),
    .rdata_o (rdata_o),
    .gdata_o (gdata_o),
    .bdata_o (bdata_o)
  );

  assign obs = {vsync_o, hsync_o, dval_o, sof_o, rdata_o, gdata_o, bdata_o};

  always #5 px_clk = ~px_clk;

  // Reference: expected outputs for enabled-cycle index t since the last restart.
  function automatic logic [27:0] model_out(input int t, input logic [2:0] md, input logic [23:0] sc);
    int p, fr, h, v, x, y, xs, off;
    logic hs, vs, act, sof;
    logic [23:0] rgb;
    p = t % FT;  fr = t / FT;
    h = p % H_TOT;  v = p / H_TOT;
    hs = h < H_SYNC;  vs = v < V_SYNC;
    act = (h >= HS) && (h < HS + H_ACT) && (v >= VS) && (v < VS + V_ACT);
    x = h - HS;  y = v - VS;
    off = 0;
`ifdef TPG_SCROLL_EN
    off = fr % H_ACT;
`endif
    xs = (x + off + H_ACT) % H_ACT;
    rgb = 24'h0;
    if (act) begin
      case (md)
        3'd0: rgb = sc;
        3'd1: if (xs / (H_ACT / 8) < 8) rgb = BAR_COL[xs / (H_ACT / 8)];
        3'd2: rgb = {3{8'(xs)}};
        3'd3: if ((((xs >> CHK) ^ (y >> CHK)) & 1) == 1) rgb = 24'hFFFFFF;
        default: rgb = 24'h0;
      endcase
    end
    sof = act && (x == 0) && (y == 0);
    return {~vs, ~hs, act, sof, rgb};
  endfunction

  int          tcnt;
  logic [2:0]  m_mode;
  logic [23:0] m_solid;
  logic [27:0] exp_o;

  always @(posedge px_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tcnt <= 0; m_mode <= 3'd0; m_solid <= 24'h0; exp_o <= IDLE;
    end else if (!en) begin
      tcnt <= 0; exp_o <= IDLE;
    end else begin
      if (tcnt % FT == 0) begin
        m_mode <= mode_i; m_solid <= solid_i;
      end
      exp_o <= model_out(tcnt, m_mode, m_solid);
      tcnt <= tcnt + 1;
    end
  end

  task automatic restart();
    @(negedge px_clk); en = 1'b0;
    @(negedge px_clk); en = 1'b1;
  endtask

  task automatic test_reset();
    #2 sys_rst = 1'b1;
    #1 checks++;
    if (obs !== IDLE) begin errors++; $display("FAIL reset_async_idle got %h want %h", obs, IDLE); end
    repeat (3) begin
      @(negedge px_clk); checks++;
      if (obs !== IDLE) begin errors++; $display("FAIL reset_held_idle got %h want %h", obs, IDLE); end
    end
    en = 1'b1; mode_i = 3'd0; solid_i = 24'h0;
    sys_rst = 1'b0;
    @(negedge px_clk); checks++;
    if ({vsync_o, hsync_o} !== 2'b00) begin
      errors++; $display("FAIL cold_first_sync got %b want 00", {vsync_o, hsync_o});
    end
  endtask

  task automatic test_solid();
    int n_hs, n_vs, n_dv, n_leak;
    bit bad;
    mode_i = 3'd0; solid_i = 24'h123456;
    restart();
    n_hs = 0; n_vs = 0; n_dv = 0; n_leak = 0;
    for (int i = 0; i < FT; i++) begin
      @(negedge px_clk);
      if (!hsync_o) n_hs++;
      if (!vsync_o) n_vs++;
      if (dval_o) n_dv++;
      if (!dval_o && {rdata_o, gdata_o, bdata_o} != 24'h0) n_leak++;
      if (dval_o && {rdata_o, gdata_o, bdata_o} != 24'h123456) n_leak++;
    end
    checks++; if (n_hs !== V_TOT * H_SYNC) begin errors++; $display("FAIL solid_hsync_clocks got %0d want %0d", n_hs, V_TOT * H_SYNC); end
    checks++; if (n_vs !== V_SYNC * H_TOT) begin errors++; $display("FAIL solid_vsync_clocks got %0d want %0d", n_vs, V_SYNC * H_TOT); end
    checks++; if (n_dv !== V_ACT * H_ACT) begin errors++; $display("FAIL solid_dval_clocks got %0d want %0d", n_dv, V_ACT * H_ACT); end
    checks++; if (n_leak !== 0) begin errors++; $display("FAIL solid_rgb_gating got %0d bad pixels want 0", n_leak); end
    solid_i = 24'($urandom);
    bad = 0;
    for (int i = 0; i < 2 * FT && !bad; i++) begin
      @(negedge px_clk); checks++;
      if (obs !== exp_o) begin errors++; bad = 1; $display("FAIL solid_model cyc %0d got %h want %h", i, obs, exp_o); end
    end
  endtask

  task automatic test_bars();
    bit got, bad;
    mode_i = 3'd1;
    restart();
    got = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge px_clk);
      if (sof_o) begin got = 1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL bars_sof_timeout got none want pulse"); end
    for (int x = 0; x < H_ACT; x++) begin
      checks++;
      if ({rdata_o, gdata_o, bdata_o} !== BAR_COL[x / 2]) begin
        errors++; $display("FAIL bars_pixel x=%0d got %h want %h", x, {rdata_o, gdata_o, bdata_o}, BAR_COL[x / 2]);
      end
      @(negedge px_clk);
    end
    bad = 0;
    for (int i = 0; i < FT && !bad; i++) begin
      @(negedge px_clk); checks++;
      if (obs !== exp_o) begin errors++; bad = 1; $display("FAIL bars_model cyc %0d got %h want %h", i, obs, exp_o); end
    end
  endtask

  task automatic test_mode_switch();
    int n_sof;
    bit bad;
    mode_i = 3'd0; solid_i = 24'($urandom);
    restart();
    n_sof = 0; bad = 0;
    for (int i = 0; i < 3 * FT && !bad; i++) begin
      @(negedge px_clk); checks++;
      if (obs !== exp_o) begin errors++; bad = 1; $display("FAIL switch_model cyc %0d got %h want %h", i, obs, exp_o); end
      if (sof_o) n_sof++;
      if (i == 80) begin mode_i = 3'd3; solid_i = 24'($urandom); end
    end
    checks++; if (n_sof !== 3) begin errors++; $display("FAIL switch_sof_count got %0d want 3", n_sof); end
  endtask

  task automatic test_reset_async();
    bit bad;
    mode_i = 3'd1;
    restart();
    repeat (60) @(negedge px_clk);
    @(posedge px_clk);
    #3 sys_rst = 1'b1;
    #1 checks++;
    if (obs !== IDLE) begin errors++; $display("FAIL midline_reset_idle got %h want %h", obs, IDLE); end
    @(negedge px_clk); sys_rst = 1'b0;
    @(negedge px_clk); checks++;
    if (hsync_o !== 1'b0) begin errors++; $display("FAIL reset_release_hsync got %b want 0", hsync_o); end
    bad = 0;
    for (int i = 0; i < FT + 10 && !bad; i++) begin
      @(negedge px_clk); checks++;
      if (obs !== exp_o) begin errors++; bad = 1; $display("FAIL after_reset_model cyc %0d got %h want %h", i, obs, exp_o); end
    end
  endtask

  task automatic test_enable();
    int lat;
    bit bad;
    mode_i = 3'd2;
    @(negedge px_clk); en = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000 && !bad; i++) begin
      @(negedge px_clk); checks++;
      if (obs !== IDLE) begin errors++; bad = 1; $display("FAIL en_low_idle cyc %0d got %h want %h", i, obs, IDLE); end
    end
    en = 1'b1;
    lat = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge px_clk);
      if (dval_o) begin lat = k; break; end
    end
    checks++;
    if (lat !== VS * H_TOT + HS + 1) begin errors++; $display("FAIL en_first_dval got %0d want %0d", lat, VS * H_TOT + HS + 1); end
    bad = 0;
    for (int i = 0; i < FT && !bad; i++) begin
      @(negedge px_clk); checks++;
      if (obs !== exp_o) begin errors++; bad = 1; $display("FAIL en_model cyc %0d got %h want %h", i, obs, exp_o); end
    end
  endtask

  task automatic test_scroll();
    bit got;
    int want;
    mode_i = 3'd2;
    restart();
    for (int n = 0; n < 20; n++) begin
      got = 0;
      for (int k = 0; k < 400; k++) begin
        @(negedge px_clk);
        if (sof_o) begin got = 1; break; end
      end
      want = 0;
`ifdef TPG_SCROLL_EN
      want = n % H_ACT;
`endif
      checks++;
      if (!got || bdata_o !== 8'(want)) begin
        errors++; $display("FAIL scroll_first_pixel frame %0d got %0d want %0d", n, bdata_o, want);
      end
    end
  endtask

  task automatic test_random();
    bit bad;
    mode_i = 3'($urandom_range(0, 3)); solid_i = 24'($urandom);
    restart();
    bad = 0;
    for (int i = 0; i < 6 * FT && !bad; i++) begin
      @(negedge px_clk); checks++;
      if (obs !== exp_o) begin errors++; bad = 1; $display("FAIL random_model cyc %0d got %h want %h", i, obs, exp_o); end
      if ($urandom_range(0, 39) == 0) begin
        mode_i = 3'($urandom_range(0, 7)); solid_i = 24'($urandom);
      end
    end
  endtask

  initial begin
    px_clk = 1'b0; sys_rst = 1'b0; en = 1'b0; mode_i = 3'd0; solid_i = 24'h0;
    test_reset();
    test_solid();
    test_bars();
    test_mode_switch();
    test_reset_async();
    test_enable();
    test_scroll();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
